sistema_seg7_scan: RTL and testbench

- Multiplexed two-digit seven-segment scanner. Consumes the 8-bit out_port of the system's Avalon output PIO as two hex nibbles.
- Time-multiplexes the nibbles onto one shared segment bus with per-digit enables, leading-zero blanking and PWM brightness.
- Latches the PIO value only at frame boundaries, so a CPU write mid-scan cannot tear the display.
- Sits between the PIO register and the board's display pins, in the same clock/reset domain.

---
 rtl/sistema_seg7_scan.sv | 111 +++++++++++
 tb/tb_sistema_seg7_scan.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sistema_seg7_scan.sv
// Two-digit multiplexed seven-segment scanner for an 8-bit PIO value, with PWM dimming and leading-zero blanking.
// Latency: seg_n/dig_n registered one clk after cnt/sel/shadow/enable; a new PIO value shows from the slot after frame_tick.
// Backpressure: none; scanning free-runs and data_in is sampled only at frame boundaries, so mid-frame writes never tear.
module sistema_seg7_scan #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter int unsigned DUTY_NUM = 50000,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] data_in,
   input  logic       enable,
   output logic [6:0] seg_n,
   output logic [1:0] dig_n,
   output logic       frame_tick
);

   // Counter just wide enough for 0..SCAN_DIV-1; SCAN_DIV is at least 2.
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt;
   logic          sel;
   logic [7:0]    shadow;
   logic          slot_end;
   logic          frame_end;
   logic          lit;
   logic [3:0]    nib;
   logic [6:0]    hex_on;

   // Active-high {g,f,e,d,c,b,a} patterns for one hex digit.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      s = 7'h00;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         4'hF: s = 7'h71;
         default: s = 7'h00;
      endcase
      return s;
   endfunction

   assign slot_end  = (cnt == CNT_LAST);
   assign frame_end = slot_end && sel;

   // Prescaler: cnt runs 0..SCAN_DIV-1 and sel flips at the end of every slot.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         sel <= 1'b0;
      end else if (slot_end) begin
         cnt <= '0;
         sel <= ~sel;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // Capture the PIO value only at the end of the digit1 slot, flagging it with a one-cycle pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shadow     <= 8'h00;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frame_end;
         if (frame_end) begin
            shadow <= data_in;
         end
      end
   end

   // Pick the active nibble and decide whether the active digit is lit in this cycle.
   always_comb begin
      nib    = sel ? shadow[7:4] : shadow[3:0];
      hex_on = hex7(nib);
      lit    = enable && (32'(cnt) < DUTY_NUM);
      // Only the upper digit is ever blanked; digit0 always shows its nibble, even 0.
      if (sel && BLANK_LZ && (shadow[7:4] == 4'h0)) begin
         lit = 1'b0;
      end
   end

   // Registered pin drivers; a single sel value per cycle guarantees at most one digit enable low.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         seg_n <= 7'h7F;
         dig_n <= 2'b11;
      end else if (lit) begin
         seg_n <= ~hex_on;
         dig_n <= sel ? 2'b01 : 2'b10;
      end else begin
         seg_n <= 7'h7F;
         dig_n <= 2'b11;
      end
   end

endmodule

// File: tb/tb_sistema_seg7_scan.sv
// Bench for sistema_seg7_scan: four instances (nominal, no blanking, duty 0, full duty) driven by shared inputs.
// Expected frames are queued when data is driven and compared one frame later, after the frame boundary captures it.
// Hand sequences cover reset, tearing, enable drop and mid-frame reset.
module tb_sistema_seg7_scan;

   typedef struct {
      logic [7:0] dat;
      logic [6:0] seg0;   // active-low segments for the low nibble
      logic [6:0] seg1;   // active-low segments for the high nibble (before blanking)
   } vec_t;

   localparam int NV = 10;
   localparam int DUTY_V [4] = '{3, 3, 0, 4};
   localparam bit BLANK_V [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic [7:0] data_in = 8'hFF;
   logic       enable = 1'b1;
   logic [6:0] seg_a [4];
   logic [1:0] dig_a [4];
   logic       ft_a [4];

   int n_chk = 0;
   int n_pass = 0;

   vec_t vecs [NV];
   vec_t exp_q [$];
   vec_t cur;
   vec_t rec00, rec12, rec34, rec56, rec78;

   always #5 clk = ~clk;

   sistema_seg7_scan #(.SCAN_DIV(4), .DUTY_NUM(3), .BLANK_LZ(1'b1)) u_nom (
      .clk(clk), .reset_n(reset_n), .data_in(data_in), .enable(enable),
      .seg_n(seg_a[0]), .dig_n(dig_a[0]), .frame_tick(ft_a[0]));
   sistema_seg7_scan #(.SCAN_DIV(4), .DUTY_NUM(3), .BLANK_LZ(1'b0)) u_nolz (
      .clk(clk), .reset_n(reset_n), .data_in(data_in), .enable(enable),
      .seg_n(seg_a[1]), .dig_n(dig_a[1]), .frame_tick(ft_a[1]));
   sistema_seg7_scan #(.SCAN_DIV(4), .DUTY_NUM(0), .BLANK_LZ(1'b1)) u_d0 (
      .clk(clk), .reset_n(reset_n), .data_in(data_in), .enable(enable),
      .seg_n(seg_a[2]), .dig_n(dig_a[2]), .frame_tick(ft_a[2]));
   sistema_seg7_scan #(.SCAN_DIV(4), .DUTY_NUM(4), .BLANK_LZ(1'b1)) u_d4 (
      .clk(clk), .reset_n(reset_n), .data_in(data_in), .enable(enable),
      .seg_n(seg_a[3]), .dig_n(dig_a[3]), .frame_tick(ft_a[3]));

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // All instances dark with no frame pulse (used while reset is held).
   task automatic chk_dark(input string tag);
      for (int u = 0; u < 4; u++) begin
         chk($sformatf("%s seg_n u%0d", tag, u), {1'b0, seg_a[u]}, 8'h7F);
         chk($sformatf("%s dig_n u%0d", tag, u), {6'd0, dig_a[u]}, 8'h03);
         chk($sformatf("%s frame_tick u%0d", tag, u), {7'd0, ft_a[u]}, 8'h00);
      end
   endtask

   // Called just after a frame boundary (or reset release); checks the 8 following cycles of every
   // instance against record r. After sample mid_k, data_in/enable are changed to mid_dat/mid_en.
   task automatic check_frame(input vec_t r, input int mid_k, input logic [7:0] mid_dat, input logic mid_en);
      logic       en_m;
      logic       lit;
      int         cnt_m;
      int         sel_m;
      logic [1:0] ed;
      logic [6:0] es;
      en_m = enable;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk);
         @(negedge clk);
         cnt_m = (k - 1) % 4;
         sel_m = (k - 1) / 4;
         for (int u = 0; u < 4; u++) begin
            lit = en_m && (cnt_m < DUTY_V[u]) &&
                  !((sel_m == 1) && BLANK_V[u] && (r.dat[7:4] == 4'h0));
            ed = !lit ? 2'b11 : ((sel_m == 1) ? 2'b01 : 2'b10);
            es = !lit ? 7'h7F : ((sel_m == 1) ? r.seg1 : r.seg0);
            chk($sformatf("dig_n d=%0h u%0d k%0d", r.dat, u, k), {6'd0, dig_a[u]}, {6'd0, ed});
            chk($sformatf("seg_n d=%0h u%0d k%0d", r.dat, u, k), {1'b0, seg_a[u]}, {1'b0, es});
            chk($sformatf("frame_tick d=%0h u%0d k%0d", r.dat, u, k), {7'd0, ft_a[u]}, {7'd0, (k == 8)});
         end
         if (k == mid_k) begin
            data_in = mid_dat;
            enable  = mid_en;
            en_m    = mid_en;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{8'h3A, 7'h08, 7'h30};
      vecs[1] = '{8'h05, 7'h12, 7'h40};
      vecs[2] = '{8'h12, 7'h24, 7'h79};
      vecs[3] = '{8'h76, 7'h02, 7'h78};
      vecs[4] = '{8'h98, 7'h00, 7'h10};
      vecs[5] = '{8'hBC, 7'h46, 7'h03};
      vecs[6] = '{8'hDE, 7'h06, 7'h21};
      vecs[7] = '{8'hF0, 7'h40, 7'h0E};
      vecs[8] = '{8'h00, 7'h40, 7'h40};
      vecs[9] = '{8'hA1, 7'h79, 7'h08};
      rec00 = '{8'h00, 7'h40, 7'h40};
      rec12 = '{8'h12, 7'h24, 7'h79};
      rec34 = '{8'h34, 7'h19, 7'h30};
      rec56 = '{8'h56, 7'h02, 7'h12};
      rec78 = '{8'h78, 7'h00, 7'h78};

      // Power-on reset with data_in = FF; outputs must be dark while reset is held.
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk_dark("por_assert");
      repeat (3) @(negedge clk);
      #1;
      chk_dark("por_hold");
      @(negedge clk);
      reset_n = 1'b1;

      // Reset frame shows "0" on digit0 with digit1 blanked; table data follows one frame behind.
      exp_q.push_back(rec00);
      for (int i = 0; i < NV; i++) begin
         data_in = vecs[i].dat;
         exp_q.push_back(vecs[i]);
         cur = exp_q.pop_front();
         check_frame(cur, 0, 8'h00, 1'b1);
      end

      // Tearing: 12 is captured, then data_in moves to 34 inside the digit0 slot of the frame showing 12.
      data_in = 8'h12;
      exp_q.push_back(rec12);
      cur = exp_q.pop_front();
      check_frame(cur, 0, 8'h00, 1'b1);
      exp_q.push_back(rec34);
      cur = exp_q.pop_front();
      check_frame(cur, 2, 8'h34, 1'b1);
      exp_q.push_back(rec34);
      cur = exp_q.pop_front();
      check_frame(cur, 0, 8'h00, 1'b1);

      // Enable dropped while digit0 is lit, a fully dark frame, then enable restored.
      data_in = 8'h56;
      exp_q.push_back(rec56);
      cur = exp_q.pop_front();
      check_frame(cur, 2, 8'h56, 1'b0);
      exp_q.push_back(rec56);
      cur = exp_q.pop_front();
      check_frame(cur, 0, 8'h00, 1'b0);
      enable = 1'b1;
      exp_q.push_back(rec56);
      cur = exp_q.pop_front();
      check_frame(cur, 0, 8'h00, 1'b1);

      // Reset in the middle of a lit digit0 slot: dark immediately, shadow cleared after release.
      data_in = 8'h78;
      repeat (2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk_dark("mid_reset");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      exp_q.delete();
      exp_q.push_back(rec00);
      exp_q.push_back(rec78);
      cur = exp_q.pop_front();
      check_frame(cur, 0, 8'h00, 1'b1);
      cur = exp_q.pop_front();
      check_frame(cur, 0, 8'h00, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
